mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multicycle control FSM for the MIPS datapath: sequences shared memory, ALU, register file and PC across fetch/decode/execute/memory/writeback cycles. Decodes the 6-bit opcode from the instruction register and issues per-cycle datapath strobes. Stalls on a memory-ready handshake. Flags unsupported opcodes without corrupting architectural state.

Parameters:
OP_RTYPE, 6'd0, R-type opcode
OP_BEQ, 6'd4, branch-equal opcode
OP_J, 6'd2, jump opcode
OP_ADDI, 6'd8, add-immediate opcode
OP_LW, 6'd35, load-word opcode
OP_SW, 6'd43, store-word opcode

Ports:
CLK  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Opcode  input  6  IR[31:26], valid from DECODE onward
MemReady  input  1  memory completes current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero
IorD  output  1  0 = PC addresses memory, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load instruction register
MemtoReg  output  1  writeback data from MDR
RegDst  output  1  1 = rd, 0 = rt
RegWrite  output  1  register file write
ALUSrcA  output  1  0 = PC, 1 = register A
ALUSrcB  output  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
ALUOp  output  2  0 = add, 1 = sub, 2 = funct field
PCSource  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
IllegalOp  output  1  one-cycle pulse on unsupported opcode
InstrDone  output  1  one-cycle pulse on final cycle of every instruction
State  output  4  current state encoding (debug)

Behaviour:
- State register updates on CLK rising edge. Outputs are combinational from state, plus MemReady where stated.
- Reset low, asynchronous: state = FETCH (0). All outputs forced 0, including State = 0, until Reset returns high. Reset mid-instruction abandons it; no further strobes issue.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RCOMP 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, ILLEGAL 12. Encodings 13-15 go to FETCH with all strobes 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0. IRWrite=PCWrite=MemReady. Holds while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut). Opcode sampled this cycle. Next state: lw/sw -> MEMADR; R-type -> EXEC; beq -> BRANCH; j -> JUMP; addi -> ADDIEX; anything else -> ILLEGAL.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Goes to MEMRD if lw, MEMWR if sw.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady=1. InstrDone=MemReady. Goes to FETCH when MemReady=1.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Goes to RCOMP.
- RCOMP: RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1, InstrDone=1. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=2, InstrDone=1. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1. Goes to FETCH.
- ILLEGAL: IllegalOp=1, InstrDone=1. All write strobes 0. Goes to FETCH; PC has already advanced by 4.
- Any output not listed for a state is 0.
- MemRead and MemWrite are never high in the same cycle. Only one of RegWrite/MemWrite/PCWrite-class writes is issued per state, except in FETCH.
- Latency, zero-wait memory: lw 5 cycles; sw, R-type, addi 4; beq, j, illegal 3. Each wait cycle on MemReady adds 1.

Test Plan:
- Reset low mid-EXEC, MemReady=1 -> State=0 and all strobes 0 immediately (asynchronous). After release, FETCH with MemRead=1, IRWrite=1.
- Opcode=0, MemReady=1 constant -> states 0,1,6,7. RegWrite=1 and RegDst=1 only in cycle 4; InstrDone pulses once.
- Opcode=35, MemReady low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4. MemRead and IorD held through the wait; RegWrite=1 with MemtoReg=1 in the last cycle.
- Opcode=43, MemReady low 3 cycles in FETCH -> FETCH held 4 cycles with IRWrite=0 until MemReady=1. MEMWR asserts MemWrite=1 with RegWrite=0.
- Opcode=4, then Opcode=2 -> BRANCH: PCWriteCond=1, PCSource=1, ALUOp=1. JUMP: PCWrite=1, PCSource=2. Each takes 3 cycles.
- Opcode=63 -> states 0,1,12. IllegalOp pulses 1 cycle, no RegWrite/MemWrite; next instruction fetches normally.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and issues per-cycle datapath strobes, stalling on the memory-ready handshake.
module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'd0,
    parameter logic [5:0] OP_BEQ   = 6'd4,
    parameter logic [5:0] OP_J     = 6'd2,
    parameter logic [5:0] OP_ADDI  = 6'd8,
    parameter logic [5:0] OP_LW    = 6'd35,
    parameter logic [5:0] OP_SW    = 6'd43
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic       InstrDone,
    output logic [3:0] State
);

    localparam int unsigned ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RCOMP   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        ILLEGAL = 4'd12
    } state_t;

    state_t state, state_nxt;
    logic   is_sw;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
    logic [1:0] alu_src_b, alu_op, pc_source;

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Remember load vs store at decode so MEMADR does not depend on a later opcode
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            is_sw <= 1'b0;
        end else if (state == DECODE) begin
            is_sw <= (Opcode == OP_SW);
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_nxt     = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = MemReady;
                pc_write  = MemReady;
                state_nxt = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'd3;
                if (Opcode == OP_LW || Opcode == OP_SW) state_nxt = MEMADR;
                else if (Opcode == OP_RTYPE)            state_nxt = EXEC;
                else if (Opcode == OP_BEQ)              state_nxt = BRANCH;
                else if (Opcode == OP_J)                state_nxt = JUMP;
                else if (Opcode == OP_ADDI)             state_nxt = ADDIEX;
                else                                    state_nxt = ILLEGAL;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_nxt = is_sw ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read  = 1'b1;
                i_or_d    = 1'b1;
                state_nxt = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = MemReady;
                state_nxt  = MemReady ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                state_nxt = RCOMP;
            end
            RCOMP: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                instr_done    = 1'b1;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                instr_done = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_nxt = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ILLEGAL: begin
                illegal_op = 1'b1;
                instr_done = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Reset blanks every strobe immediately, independent of the clock
    assign PCWrite     = Reset & pc_write;
    assign PCWriteCond = Reset & pc_write_cond;
    assign IorD        = Reset & i_or_d;
    assign MemRead     = Reset & mem_read;
    assign MemWrite    = Reset & mem_write;
    assign IRWrite     = Reset & ir_write;
    assign MemtoReg    = Reset & mem_to_reg;
    assign RegDst      = Reset & reg_dst;
    assign RegWrite    = Reset & reg_write;
    assign ALUSrcA     = Reset & alu_src_a;
    assign ALUSrcB     = Reset ? alu_src_b : 2'd0;
    assign ALUOp       = Reset ? alu_op    : 2'd0;
    assign PCSource    = Reset ? pc_source : 2'd0;
    assign IllegalOp   = Reset & illegal_op;
    assign InstrDone   = Reset & instr_done;
    assign State       = Reset ? state : 4'd0;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: expected per-cycle strobe traces
// are generated from each instruction's cycle recipe and compared every cycle.
module tb_mips_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp, InstrDone;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    mips_multicycle_ctrl dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .IllegalOp(IllegalOp), .InstrDone(InstrDone),
        .State(State)
    );

    always #5 CLK = ~CLK;

    // Flag bit positions within the 12-bit strobe word
    localparam int F_PCW  = 1 << 11;
    localparam int F_PCWC = 1 << 10;
    localparam int F_IORD = 1 << 9;
    localparam int F_MR   = 1 << 8;
    localparam int F_MW   = 1 << 7;
    localparam int F_IRW  = 1 << 6;
    localparam int F_M2R  = 1 << 5;
    localparam int F_RDST = 1 << 4;
    localparam int F_RW   = 1 << 3;
    localparam int F_SRCA = 1 << 2;
    localparam int F_ILL  = 1 << 1;
    localparam int F_DONE = 1 << 0;

    typedef struct {
        bit          mr;
        logic [21:0] exp;
    } cyc_t;

    cyc_t trace[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [21:0] ev(input int st, input int flags, input int srcb,
                                       input int aluop, input int pcsrc);
        return {4'(st), 2'(srcb), 2'(aluop), 2'(pcsrc), 12'(flags)};
    endfunction

    function automatic logic [21:0] obs();
        return {State, ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond, IorD, MemRead,
                MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp, InstrDone};
    endfunction

    task automatic push(input bit mr, input logic [21:0] e);
        cyc_t c;
        c.mr  = mr;
        c.exp = e;
        trace.push_back(c);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction
    task automatic gen(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(1'b0, ev(0, F_MR, 1, 0, 0));
        push(1'b1, ev(0, F_MR | F_IRW | F_PCW, 1, 0, 0));
        push(1'($urandom_range(0, 1)), ev(1, 0, 3, 0, 0));
        case (op)
            6'd35: begin
                push(1'($urandom_range(0, 1)), ev(2, F_SRCA, 2, 0, 0));
                for (int i = 0; i < mw; i++) push(1'b0, ev(3, F_MR | F_IORD, 0, 0, 0));
                push(1'b1, ev(3, F_MR | F_IORD, 0, 0, 0));
                push(1'($urandom_range(0, 1)), ev(4, F_RW | F_M2R | F_DONE, 0, 0, 0));
            end
            6'd43: begin
                push(1'($urandom_range(0, 1)), ev(2, F_SRCA, 2, 0, 0));
                for (int i = 0; i < mw; i++) push(1'b0, ev(5, F_MW | F_IORD, 0, 0, 0));
                push(1'b1, ev(5, F_MW | F_IORD | F_DONE, 0, 0, 0));
            end
            6'd0: begin
                push(1'($urandom_range(0, 1)), ev(6, F_SRCA, 0, 2, 0));
                push(1'($urandom_range(0, 1)), ev(7, F_RW | F_RDST | F_DONE, 0, 0, 0));
            end
            6'd4: push(1'($urandom_range(0, 1)), ev(8, F_SRCA | F_PCWC | F_DONE, 0, 1, 1));
            6'd2: push(1'($urandom_range(0, 1)), ev(9, F_PCW | F_DONE, 0, 0, 2));
            6'd8: begin
                push(1'($urandom_range(0, 1)), ev(10, F_SRCA, 2, 0, 0));
                push(1'($urandom_range(0, 1)), ev(11, F_RW | F_DONE, 0, 0, 0));
            end
            default: push(1'($urandom_range(0, 1)), ev(12, F_ILL | F_DONE, 0, 0, 0));
        endcase
    endtask

    // Play one instruction; entered and left mid-cycle, away from the clock edge
    task automatic run(input string name, input logic [5:0] op, input int fw, input int mw);
        int c = 0;
        int done_cnt = 0;
        int exp_len;
        trace.delete();
        gen(op, fw, mw);
        exp_len = trace.size();
        Opcode = op;
        while (trace.size() > 0) begin
            cyc_t e = trace.pop_front();
            MemReady = e.mr;
            #1;
            check($sformatf("%s c%0d", name, c), 32'(obs()), 32'(e.exp));
            check($sformatf("%s c%0d rdwr", name, c), 32'(MemRead & MemWrite), 32'd0);
            done_cnt += int'(InstrDone);
            c++;
            @(posedge CLK);
            #1;
        end
        check($sformatf("%s done_pulses", name), 32'(done_cnt), 32'd1);
        check($sformatf("%s next_fetch", name), 32'(State), 32'd0);
        check($sformatf("%s cycles", name), 32'(c), 32'(exp_len));
    endtask

    logic [5:0] ops [7];

    initial begin
        ops[0] = 6'd0; ops[1] = 6'd4; ops[2] = 6'd2; ops[3] = 6'd8;
        ops[4] = 6'd35; ops[5] = 6'd43; ops[6] = 6'd63;
        Reset = 1'b0;
        MemReady = 1'b1;
        Opcode = 6'd0;
        #12;
        check("reset_outputs", 32'(obs()), 32'd0);
        @(posedge CLK);
        #3;
        Reset = 1'b1;
        #1;

        run("rtype", 6'd0, 0, 0);
        run("lw_wait2", 6'd35, 0, 2);
        run("sw_fwait3", 6'd43, 3, 0);
        run("beq", 6'd4, 0, 0);
        run("j", 6'd2, 0, 0);
        run("illegal", 6'd63, 0, 0);
        run("after_ill", 6'd8, 0, 0);

        // Asynchronous reset in the middle of EXEC
        Opcode = 6'd0;
        MemReady = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("pre_reset_exec", 32'(State), 32'd6);
        Reset = 1'b0;
        #1;
        check("async_reset", 32'(obs()), 32'd0);
        @(posedge CLK); #1;
        check("held_reset", 32'(obs()), 32'd0);
        #2;
        Reset = 1'b1;
        #1;
        run("post_reset_j", 6'd2, 0, 0);

        for (int i = 0; i < 150; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 6)];
            if (op == 6'd63) op = 6'($urandom_range(0, 63));
            run($sformatf("rnd%0d", i), op,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
